// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped 8N1 UART with TX/RX FIFOs,
// 16x oversampling baud generator and maskable interrupt.

module uart_mmio_fifo_buf #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + ONE;
      if (pop)  rp <= rp + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign count = wp - rp;
  assign full  = count == CAP;
  assign empty = wp == rp;
endmodule

module uart_mmio_fifo #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DIV_DEFAULT = 16'd26,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irqout
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic       hit;
  logic [2:0] off;
  logic       wr_tx, rd_rx, wr_st, wr_ctrl, wr_div;

  assign hit     = addr[31:5] == BASE_ADDR[31:5];
  assign off     = addr[4:2];
  assign wr_tx   = wr & hit & (off == 3'd0);
  assign rd_rx   = rd & hit & (off == 3'd1);
  assign wr_st   = wr & hit & (off == 3'd2);
  assign wr_ctrl = wr & hit & (off == 3'd3);
  assign wr_div  = wr & hit & (off == 3'd4);

  logic [2:0]  ctrl;
  logic        en;
  logic [15:0] div;
  logic [15:0] bcnt;
  logic        tick;

  assign en   = ctrl[0];
  assign tick = en & (bcnt == div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
      div  <= DIV_DEFAULT;
    end else begin
      if (wr_ctrl) ctrl <= wdata[2:0];
      if (wr_div)  div  <= wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   bcnt <= '0;
    else if (!en || wr_div)       bcnt <= '0;
    else if (bcnt == div)         bcnt <= '0;
    else                          bcnt <= bcnt + 16'd1;
  end

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

  uart_mmio_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .reset(reset),
    .push(tx_push), .pop(tx_pop),
    .din(wdata[7:0]), .dout(tx_head),
    .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  logic [7:0] rx_sh;

  uart_mmio_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .reset(reset),
    .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(rx_head),
    .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  assign tx_push = wr_tx & ~tx_full;
  assign rx_pop  = rd_rx & ~rx_empty;

  logic [1:0] tx_st;
  logic [3:0] tx_tc;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic       tx_end;
  logic       tx_busy;

  assign tx_end  = tick & (tx_tc == 4'hf);
  assign tx_busy = tx_st != S_IDLE;
  // STOP hands straight to START so queued bytes go out gapless
  assign tx_pop  = en & ~tx_empty &
                   ((tx_st == S_IDLE) |
                    ((tx_st == S_STOP) & tx_end));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st  <= S_IDLE;
      tx_tc  <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (!en) begin
      tx_st  <= S_IDLE;
      tx_tc  <= '0;
      tx_bit <= '0;
    end else begin
      if (tx_busy && tick) tx_tc <= tx_tc + 4'd1;
      if (tx_pop) begin
        tx_st <= S_START;
        tx_sh <= tx_head;
        tx_tc <= '0;
      end else begin
        case (tx_st)
          S_START: if (tx_end) begin
            tx_st  <= S_DATA;
            tx_bit <= '0;
          end
          S_DATA: if (tx_end) begin
            tx_sh  <= {1'b1, tx_sh[7:1]};
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_st <= S_STOP;
          end
          S_STOP: if (tx_end) tx_st <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign uart_tx = ~((tx_st == S_START) |
                     ((tx_st == S_DATA) & ~tx_sh[0]));

  logic       rx_s1, rx_s2;
  logic [1:0] rx_st;
  logic [3:0] rx_tc;
  logic [2:0] rx_bit;
  logic       rx_end, rx_mid, rx_last;
  logic       ovr_set, fe_set, txo_set;

  assign rx_end  = tick & (rx_tc == 4'hf);
  assign rx_mid  = tick & (rx_tc == 4'd7);
  assign rx_last = en & (rx_st == S_STOP) & rx_end;
  assign rx_push = rx_last & rx_s2 & ~rx_full;
  assign ovr_set = rx_last & rx_s2 & rx_full;
  assign fe_set  = rx_last & ~rx_s2;
  assign txo_set = wr_tx & tx_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st  <= S_IDLE;
      rx_tc  <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else if (!en) begin
      rx_st  <= S_IDLE;
      rx_tc  <= '0;
      rx_bit <= '0;
    end else begin
      if ((rx_st != S_IDLE) && tick) rx_tc <= rx_tc + 4'd1;
      case (rx_st)
        S_IDLE: if (!rx_s2) begin
          rx_st <= S_START;
          rx_tc <= '0;
        end
        // mid-start recheck rejects short glitches
        S_START: if (rx_mid) begin
          rx_tc  <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_end) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= S_STOP;
        end
        S_STOP: if (rx_end) rx_st <= S_IDLE;
        default: ;
      endcase
    end
  end

  logic rx_ovr, frame_err, tx_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
      irqout    <= 1'b0;
    end else begin
      rx_ovr    <= ovr_set | (rx_ovr & ~(wr_st & wdata[4]));
      frame_err <= fe_set | (frame_err & ~(wr_st & wdata[5]));
      tx_ovf    <= txo_set | (tx_ovf & ~(wr_st & wdata[6]));
      irqout    <= (ctrl[1] & ~rx_empty) |
                   (ctrl[2] & tx_empty & ~tx_busy) |
                   (ctrl[1] & (rx_ovr | frame_err));
    end
  end

  logic [7:0]  rx_cnt8;
  logic [31:0] status;

  assign rx_cnt8 = 8'(rx_count);
  assign status  = {16'h0, rx_cnt8, tx_busy, tx_ovf,
                    frame_err, rx_ovr, rx_full, rx_empty,
                    tx_empty, tx_full};

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      case (off)
        3'd1:    rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
        3'd2:    rdata = status;
        3'd3:    rdata = {29'h0, ctrl};
        3'd4:    rdata = {16'h0, div};
        default: rdata = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16], tx_count};
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: register vectors, directed serial corners and
// randomized RX/TX traffic against a queue-based reference model.

module tb_uart_mmio_fifo;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE   = 32'h4000_0020;
  localparam logic [31:0] A_TX   = BASE;
  localparam logic [31:0] A_RX   = BASE + 32'd4;
  localparam logic [31:0] A_ST   = BASE + 32'd8;
  localparam logic [31:0] A_CTRL = BASE + 32'd12;
  localparam logic [31:0] A_DIV  = BASE + 32'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        irqout;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit ovr_m = 0;
  bit fe_m = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  uart_mmio_fifo #(
    .FIFO_DEPTH(DEPTH),
    .DIV_DEFAULT(16'd26),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .uart_rx(uart_rx), .uart_tx(uart_tx),
    .irqout(irqout)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a,
                          output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[15:8] = 8'(rxq.size());
    s[1] = 1'b1;
    s[2] = rxq.size() == 0;
    s[3] = rxq.size() == DEPTH;
    s[4] = ovr_m;
    s[5] = fe_m;
    return s;
  endfunction

  // one 16-clk-per-bit frame followed by one idle bit time
  task automatic drive_rx(input logic [7:0] b, input bit stopb);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) @(negedge clk);
    end
    uart_rx = stopb;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  function automatic void model_frame(input logic [7:0] b,
                                      input bit stopb);
    if (!stopb) fe_m = 1;
    else if (rxq.size() == DEPTH) ovr_m = 1;
    else rxq.push_back(b);
  endfunction

  task automatic rx_send(input logic [7:0] b, input bit stopb);
    drive_rx(b, stopb);
    model_frame(b, stopb);
  endtask

  task automatic uart_get(input int p, output logic [7:0] b,
                          output bit ok);
    int w;
    w = 0; ok = 0; b = '0;
    while (uart_tx !== 1'b0 && w < 40 * p) begin
      @(negedge clk); w++;
    end
    if (uart_tx !== 1'b0) return;
    repeat (p / 2) @(negedge clk);
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (p) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (p) @(negedge clk);
    ok = uart_tx === 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  e;
    bit          ok;
    int          w;
    int          n;

    tbl[0]  = '{1'b0, A_ST,   32'h0, 32'h6};
    tbl[1]  = '{1'b0, A_DIV,  32'h0, 32'd26};
    tbl[2]  = '{1'b0, A_CTRL, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, A_TX,   32'h0, 32'h0};
    tbl[4]  = '{1'b0, A_RX,   32'h0, 32'h0};
    tbl[5]  = '{1'b1, A_CTRL, 32'hFFFF_FFF6, 32'h0};
    tbl[6]  = '{1'b0, A_CTRL, 32'h0, 32'h6};
    tbl[7]  = '{1'b1, A_DIV,  32'hABCD_1234, 32'h0};
    tbl[8]  = '{1'b0, A_DIV,  32'h0, 32'h1234};
    tbl[9]  = '{1'b0, BASE + 32'd20, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 32'h4000_0048, 32'h0, 32'h0};
    tbl[11] = '{1'b0, BASE + 32'd9,  32'h0, 32'h6};
    tbl[12] = '{1'b1, A_CTRL, 32'h0, 32'h0};
    tbl[13] = '{1'b1, A_DIV,  32'h0, 32'h0};
    tbl[14] = '{1'b0, A_DIV,  32'h0, 32'h0};

    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_irq", {31'h0, irqout}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].is_wr) begin
        bus_write(tbl[i].a, tbl[i].d);
      end else begin
        bus_read(tbl[i].a, d);
        check($sformatf("vec%0d", i), d, tbl[i].exp);
      end
    end
    @(negedge clk);
    addr = A_ST;
    #1 check("rdata_idle", rdata, 32'h0);

    // 0xA5 at BAUDDIV=0: 16 clocks per bit
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TX, 32'hA5);
    w = 0;
    while (uart_tx !== 1'b0 && w < 50) begin
      @(negedge clk); w++;
    end
    check("a5_start", {31'h0, uart_tx}, 32'h0);
    w = 0;
    while (uart_tx === 1'b0 && w < 40) begin
      @(negedge clk); w++;
    end
    check("a5_start_len", w, 32'd16);
    repeat (8) @(negedge clk);
    b[0] = uart_tx;
    for (int i = 1; i < 8; i++) begin
      repeat (16) @(negedge clk);
      b[i] = uart_tx;
    end
    check("a5_bits", {24'h0, b}, 32'hA5);
    repeat (16) @(negedge clk);
    check("a5_stop", {31'h0, uart_tx}, 32'h1);
    repeat (6) @(negedge clk);
    bus_read(A_ST, d);
    check("a5_busy_159", d, 32'h86);
    bus_read(A_ST, d);
    check("a5_idle_160", d, 32'h06);

    bus_write(A_CTRL, 32'h5);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", {31'h0, irqout}, 32'h1);
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    check("irq_off", {31'h0, irqout}, 32'h0);

    bus_write(A_TX, 32'h00);
    w = 0;
    while (uart_tx !== 1'b0 && w < 50) begin
      @(negedge clk); w++;
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1 check("rst_mid_tx", {31'h0, uart_tx}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    bus_read(A_ST, d);
    check("st_after_rst", d, 32'h6);
    bus_read(A_DIV, d);
    check("div_after_rst", d, 32'd26);

    // TX overflow with transmitter disabled
    bus_write(A_DIV, 32'h0);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      bus_write(A_TX, {24'h0, b});
      if (txq.size() < DEPTH) txq.push_back(b);
    end
    bus_read(A_ST, d);
    check("tx_full_ovf", d, 32'h45);
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 8; i++) begin
      uart_get(16, b, ok);
      e = txq.pop_front();
      check($sformatf("txf_ok%0d", i), {31'h0, ok}, 32'h1);
      check($sformatf("txf_b%0d", i), {24'h0, b}, {24'h0, e});
    end
    uart_get(16, b, ok);
    check("tx_no_ninth", {31'h0, ok}, 32'h0);
    bus_read(A_ST, d);
    check("tx_ovf_sticky", d, 32'h46);
    bus_write(A_ST, 32'h40);
    bus_read(A_ST, d);
    check("tx_ovf_w1c", d, 32'h06);

    // single RX frame and interrupt
    bus_write(A_CTRL, 32'h3);
    repeat (2) @(negedge clk);
    check("irq_rx_idle", {31'h0, irqout}, 32'h0);
    rx_send(8'h3C, 1'b1);
    bus_read(A_ST, d);
    check("rx1_status", d, exp_status());
    check("rx1_irq", {31'h0, irqout}, 32'h1);
    bus_read(A_RX, d);
    check("rx1_data", d, 32'h3C);
    void'(rxq.pop_front());
    bus_read(A_ST, d);
    check("rx1_empty", d, exp_status());
    repeat (2) @(negedge clk);
    check("rx1_irq_low", {31'h0, irqout}, 32'h0);

    // nine frames into an eight-deep FIFO
    for (int i = 0; i < 9; i++) rx_send(8'($urandom), 1'b1);
    bus_read(A_ST, d);
    check("rx_full_ovr", d, exp_status());
    for (int i = 0; i < 8; i++) begin
      bus_read(A_RX, d);
      e = rxq.pop_front();
      check($sformatf("rxo_b%0d", i), d, {24'h0, e});
    end
    bus_write(A_ST, 32'h10);
    ovr_m = 0;
    bus_read(A_ST, d);
    check("rx_ovr_w1c", d, exp_status());

    rx_send(8'h5A, 1'b1);
    rx_send(8'h77, 1'b0);
    bus_read(A_ST, d);
    check("frame_err", d, exp_status());
    bus_write(A_ST, 32'h20);
    fe_m = 0;

    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_ST, d);
    check("glitch", d, exp_status());

    // pop lands on the same edge as the stop-bit push
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    e = rxq[0];
    fork
      drive_rx(8'h33, 1'b1);
      begin
        @(negedge clk);
        repeat (153) @(negedge clk);
        bus_read(A_RX, d);
      end
    join
    check("simul_pop", d, {24'h0, e});
    void'(rxq.pop_front());
    model_frame(8'h33, 1'b1);
    bus_read(A_ST, d);
    check("simul_count", d, exp_status());

    // randomized RX traffic
    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(0, 3);
      if (n <= 1) begin
        rx_send(8'($urandom), $urandom_range(0, 4) != 0);
      end else if (n == 2) begin
        bus_read(A_RX, d);
        e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
        check($sformatf("rnd_rx%0d", it), d, {24'h0, e});
      end else begin
        w = int'($urandom & 32'h30);
        bus_write(A_ST, 32'(w));
        if (w[4]) ovr_m = 0;
        if (w[5]) fe_m = 0;
      end
      bus_read(A_ST, d);
      check($sformatf("rnd_st%0d", it), d, exp_status());
      repeat (2) @(negedge clk);
      check($sformatf("rnd_irq%0d", it), {31'h0, irqout},
            {31'h0, (rxq.size() != 0) | ovr_m | fe_m});
    end

    // randomized TX at several divisors
    for (int it = 0; it < 4; it++) begin
      w = $urandom_range(0, 2);
      bus_write(A_DIV, 32'(w));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        txq.push_back(b);
        bus_write(A_TX, {24'h0, b});
      end
      for (int k = 0; k < n; k++) begin
        uart_get(16 * (w + 1), b, ok);
        e = txq.pop_front();
        check($sformatf("rtx_ok%0d_%0d", it, k),
              {31'h0, ok}, 32'h1);
        check($sformatf("rtx_b%0d_%0d", it, k),
              {24'h0, b}, {24'h0, e});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
Memory-mapped UART peripheral with parametrised TX/RX FIFOs, a runtime-programmable 16x-oversampling baud generator, sticky error flags and a maskable interrupt. Connects to the CPU's peripheral bus (rd/wr/addr/wdata/rdata). Supersedes the fixed single-byte UART path used by the peripheral subsystem. Runs on the single CPU clock; no separate baud or sample clocks.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; power of 2, minimum 2
DIV_DEFAULT, 26, reset value of BAUDDIV; oversample tick period is BAUDDIV+1 clk cycles
BASE_ADDR, 32'h40000020, byte address of register 0; only addr[4:2] are decoded once addr[31:5] matches

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
rd  in  1  bus read strobe
wr  in  1  bus write strobe
addr  in  32  bus byte address
wdata  in  32  bus write data
rdata  out  32  bus read data
uart_rx  in  1  serial input (asynchronous)
uart_tx  out  1  serial output, idle high
irqout  out  1  level interrupt

Behaviour:
- Reset (reset=0, async): FIFOs empty, both FSMs IDLE, uart_tx=1, CTRL=0, BAUDDIV=DIV_DEFAULT, sticky flags 0, irqout=0.
- Register map (offset): 0x00 TXDATA W: push wdata[7:0]; reads return 0. 0x04 RXDATA R: {24'b0, head}; pops. 0x08 STATUS R: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 rx_overrun, bit5 frame_err, bit6 tx_ovf, bit7 tx_busy, [15:8] rx_count (zero-extended); W1C on bits 4-6. 0x0C CTRL RW: bit0 enable, bit1 rx_ie, bit2 tx_ie. 0x10 BAUDDIV RW [15:0].
- rdata combinational: selected register when rd=1 and address hits, else 0.
- Side effects take place on the clk edge when rd/wr is high. RXDATA read when empty returns 0, no pop. TXDATA write when full: byte dropped, tx_ovf set.
- FIFOs: circular, ptr width clog2(FIFO_DEPTH)+1. Push and pop in the same cycle are both performed; count is unchanged. Pointers wrap modulo depth.
- Baud gen: counter 0..BAUDDIV, tick pulses 1 cycle at terminal count. Held at 0 when enable=0. BAUDDIV write restarts counter at 0.
- TX FSM IDLE->START->DATA->STOP->IDLE, 16 ticks per bit, LSB first, 8N1.
  - Leaves IDLE when enable=1 and TX FIFO is non-empty; pops at START entry.
  - tx_busy=1 outside IDLE.
  - Back-to-back frames have no idle gap.
- RX path:
  - uart_rx passes through 2-flop synchroniser (reset to 1).
  - IDLE: a synchronised 0 enters START.
  - START: at tick 8, if line=1 return IDLE (glitch); else DATA.
  - DATA: sample each bit every 16 ticks.
  - STOP: sample after 16 ticks. If stop=0, set frame_err and discard the byte. Else push to RX FIFO; if full, set rx_overrun and discard.
  - Return IDLE.
- enable=0: both FSMs are forced to IDLE immediately (frame aborted, uart_tx=1). FIFO contents are kept.
- irqout registered: (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy) | (rx_ie & (rx_overrun|frame_err)).
- Sticky flag set and W1C in the same cycle: set wins.

Test Plan:
- Reset -> uart_tx=1, STATUS=0x0000_0006, BAUDDIV=26, irqout=0; assert reset mid-TX frame -> uart_tx=1 within same cycle.
- BAUDDIV=0, CTRL=1, write TXDATA 0xA5 -> uart_tx low 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each, high stop; tx_busy clears at 160 clks.
- Write 9 bytes with enable=0, FIFO_DEPTH=8 -> tx_full=1, tx_ovf=1, 8 bytes transmitted after enable; write 0x40 to STATUS -> tx_ovf=0.
- Drive 0x3C frame on uart_rx at 16 clks/bit -> rx_count=1, RXDATA read returns 0x3C, rx_empty=1 after; rx_ie=1 -> irqout high then low after pop.
- Drive 9 frames without reading -> rx_full=1, rx_overrun=1, first 8 bytes intact in order; frame with stop=0 -> frame_err=1, rx_count unchanged.
- 4-clk low glitch on uart_rx -> no byte, no error; simultaneous RX push and RXDATA pop at count 3 -> count stays 3.
